led_pwm_fader: RTL and testbench
================================

# led_pwm_fader

Downstream stage of the LED blink counter: consumes its 4-bit on/off pattern and drives the physical LEDs with PWM brightness.
Each channel fades linearly toward its target instead of switching hard: up to `max_level` when the input bit is 1, down to 0 when it is 0.
The block sits between the blink stage's `led` output and the board pins.

## Interface

- `CHANNELS`, 4: number of LED channels.
- `PWM_BITS`, 8: brightness resolution. `FULL = 2**PWM_BITS-1`.
- `STEP_DIV`, 20_000: clock cycles per one-LSB brightness step (≥2).

- `clck`  in  1: single clock. Everything is in this domain.
- `reset`  in  1: synchronous, active-high reset.
- `led_in`  in  CHANNELS: on/off pattern from the blink stage.
- `enable`  in  1: 0 blanks the outputs and freezes fading.
- `max_level`  in  PWM_BITS: brightness ceiling for "on" channels.
- `led_out`  out  CHANNELS: PWM drive to the LEDs. Registered.
- `busy`  out  1: 1 while any channel is RISE or FALL. Registered.

## Operation

- **Input registers:** `led_in` and `max_level` are registered once before use.
- **PWM counter:** `pwm_cnt` counts 0..FULL-1 and wraps, giving a period of FULL cycles.
  - `led_out[i] <= (pwm_cnt < level[i])`.
  - level 0 gives constant 0; level FULL gives constant 1.
- **Step prescaler:** `div_cnt` counts 0..STEP_DIV-1. `step_tick` is asserted for one cycle when `div_cnt == STEP_DIV-1`.
- **Per-channel target:** `led_in_q[i] ? max_level_q : 0`.
- **Per-channel FSM:** states OFF, RISE, ON, FALL. It is evaluated only on `step_tick`, and `level` and state are updated together:
  - `level < target`: `level+1`, go to RISE.
  - `level > target`: `level-1`, go to FALL.
  - `level == target`: ON if `level != 0`, else OFF. Level unchanged.
- **Arithmetic:** `level` is unsigned PWM_BITS wide, moves ±1 only, and never wraps or overshoots the target.
- **Reversal mid-ramp:** direction changes on the next `step_tick`.
- **`max_level` changed while a channel is ON:** the channel walks to the new ceiling at one step per tick.
- **`max_level == 0`:** all channels fade to OFF.
- **`enable = 0`:**
  - `led_out` is 0 from the next cycle.
  - `pwm_cnt` and `div_cnt` are held at 0.
  - `level`, state and `busy` hold.
- **`enable` 0→1:** counters restart from 0.
- **Reset (at any time, including mid-ramp):**
  - all `level` = 0, all states OFF;
  - `pwm_cnt` = 0, `div_cnt` = 0;
  - `led_out` = 0, `busy` = 0;
  - input registers = 0.

## Timing

- **`led_in` change at edge t:** visible in `led_in_q` at t+1, and acted on at the first `step_tick` after t+1. The worst-case wait is STEP_DIV cycles.
- **`level` update:** changes on the edge of `step_tick`. `led_out` reflects it from the following cycle (1-cycle output register).
- **Full ramp 0→M:** exactly M step ticks, i.e. M·STEP_DIV cycles, plus up to STEP_DIV of phase offset.
- **`busy`:** registered OR of RISE/FALL states, one cycle behind the state registers.
  - Deasserts one cycle after the tick on which the last moving channel finds `level == target`.
  - That is one tick after the final increment or decrement.
- **Simultaneous `reset` and `step_tick`:** reset wins.
- **Simultaneous `enable = 0` and `step_tick`:** no step is taken.

## Structure

- **Shared package `led_pkg`:**
  - 2-bit state encoding: OFF=0, RISE=1, ON=2, FALL=3.
  - Default `PWM_BITS` and `STEP_DIV` constants, shared with the blink stage.
- **Sub-module `led_fade_channel`:** one channel's `level` register, its FSM and the PWM comparator.
  - Inputs: `clck`, `reset`, `step_tick`, `enable`, `pwm_cnt`, `target`.
  - Outputs: `led_bit`, `moving`.
- **Top level:** contains the input registers, `pwm_cnt`, the prescaler, the `busy` OR, and CHANNELS instances of `led_fade_channel`.

## Test plan

All scenarios run with `PWM_BITS=4` (FULL=15), `STEP_DIV=4` and `enable=1` unless stated.

1. **Reset dominance:** `reset=1` for 20 cycles with `led_in=4'hF` and `max_level=15` → `led_out=0` and `busy=0` every cycle; all levels are 0 after release.
2. **Full rise:** `led_in=4'b0001`, `max_level=15` → level[0] steps 1..15 on consecutive ticks (60 cycles ±4); `busy` is 1 throughout and drops one cycle after the tick that finds `level == 15`; then `led_out[0]` is constantly 1 and `led_out[3:1]` is 0.
3. **Duty cycle:** `max_level=5`, channel 0 settled ON → `led_out[0]` is high exactly 5 of every 15 cycles, contiguous from `pwm_cnt == 0`.
4. **Fall:** from level 15, `led_in=0` → level decrements to 0 in 15 ticks; state ends OFF and `led_out[0]` is constantly 0.
5. **Reversal:** `led_in[0]` drops while rising at level 7 → next tick gives level 6 and FALL, with no step to 8.
6. **Blank and reset mid-ramp:**
   - `enable=0` at level 9 → `led_out=0` next cycle; level stays 9 for 50 cycles; ramp resumes after re-enable.
   - `reset` pulse at level 9 → level 0 and `led_out=0` on the next cycle.

Source files
------------

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pkg
//  Description : Shared constants for the LED blink / fade stages: default
//                PWM resolution, fade step divider and the 2-bit fade state
//                encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int c_PWM_BITS = 8;
    localparam int c_STEP_DIV = 20_000;

    // Fade state encoding (2 bits, fixed values)
    localparam logic [1:0] c_ST_OFF  = 2'd0;
    localparam logic [1:0] c_ST_RISE = 2'd1;
    localparam logic [1:0] c_ST_ON   = 2'd2;
    localparam logic [1:0] c_ST_FALL = 2'd3;

    // A channel counts as moving while it is ramping in either direction
    function automatic logic is_moving(input logic [1:0] state);
        return (state == c_ST_RISE) || (state == c_ST_FALL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_fade_channel.sv
`default_nettype none
// ============================================================================
//  Module      : led_fade_channel
//  Description : One LED channel: brightness level register, OFF/RISE/ON/FALL
//                fade state machine stepped by step_tick, and the registered
//                PWM comparator driving the LED bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_fade_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = c_PWM_BITS
) (
    input  logic                clck,
    input  logic                reset,
    input  logic                step_tick,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic [PWM_BITS-1:0] target,
    output logic                led_bit,
    output logic                moving
);

    localparam logic [PWM_BITS-1:0] c_LVL_ONE = PWM_BITS'(1);

    logic [PWM_BITS-1:0] r_level;
    logic [1:0]          r_state;
    logic                r_led_bit;

    // Fade FSM: on each step tick move level one LSB toward target, state follows
    always_ff @(posedge clck) begin
        if (reset) begin
            r_level <= '0;
            r_state <= c_ST_OFF;
        end else if (step_tick && enable) begin
            if (r_level < target) begin
                r_level <= r_level + c_LVL_ONE;
                r_state <= c_ST_RISE;
            end else if (r_level > target) begin
                r_level <= r_level - c_LVL_ONE;
                r_state <= c_ST_FALL;
            end else begin
                r_state <= (r_level != '0) ? c_ST_ON : c_ST_OFF;
            end
        end
    end

    // Registered PWM compare; blanked while disabled
    always_ff @(posedge clck) begin
        if (reset) begin
            r_led_bit <= 1'b0;
        end else if (!enable) begin
            r_led_bit <= 1'b0;
        end else begin
            r_led_bit <= (pwm_cnt < r_level);
        end
    end

    assign led_bit = r_led_bit;
    assign moving  = is_moving(r_state);

endmodule
`default_nettype wire

// File: rtl/led_pwm_fader.sv
`default_nettype none
// ============================================================================
//  Module      : led_pwm_fader
//  Description : Drives CHANNELS LEDs with PWM brightness, fading each channel
//                linearly toward max_level (input bit 1) or 0 (input bit 0) at
//                one LSB per STEP_DIV clock cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_fader
    import led_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int PWM_BITS = c_PWM_BITS,
    parameter int STEP_DIV = c_STEP_DIV
) (
    input  logic                clck,
    input  logic                reset,
    input  logic [CHANNELS-1:0] led_in,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] max_level,
    output logic [CHANNELS-1:0] led_out,
    output logic                busy
);

    // pwm_cnt wraps after FULL-1 so the period is FULL cycles and level FULL is solid on
    localparam logic [PWM_BITS-1:0] c_PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
    localparam int                  c_DIV_BITS = $clog2(STEP_DIV);
    localparam logic [c_DIV_BITS-1:0] c_DIV_LAST = c_DIV_BITS'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] c_PWM_ONE  = PWM_BITS'(1);
    localparam logic [c_DIV_BITS-1:0] c_DIV_ONE = c_DIV_BITS'(1);

    logic [CHANNELS-1:0]   r_led_in_q;
    logic [PWM_BITS-1:0]   r_max_level_q;
    logic [PWM_BITS-1:0]   r_pwm_cnt;
    logic [c_DIV_BITS-1:0] r_div_cnt;
    logic                  r_busy;
    logic                  w_step_tick;
    logic [CHANNELS-1:0]   w_moving;
    logic [CHANNELS-1:0]   w_led_bits;

    // Input registers ahead of all use
    always_ff @(posedge clck) begin
        if (reset) begin
            r_led_in_q    <= '0;
            r_max_level_q <= '0;
        end else begin
            r_led_in_q    <= led_in;
            r_max_level_q <= max_level;
        end
    end

    // PWM period counter and step prescaler; both parked at 0 while disabled
    always_ff @(posedge clck) begin
        if (reset || !enable) begin
            r_pwm_cnt <= '0;
            r_div_cnt <= '0;
        end else begin
            r_pwm_cnt <= (r_pwm_cnt == c_PWM_LAST) ? '0 : r_pwm_cnt + c_PWM_ONE;
            r_div_cnt <= (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + c_DIV_ONE;
        end
    end

    // Gating with enable keeps a tick coinciding with enable=0 from stepping
    assign w_step_tick = enable && (r_div_cnt == c_DIV_LAST);

    // busy is the registered OR of all channels' RISE/FALL states
    always_ff @(posedge clck) begin
        if (reset) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= |w_moving;
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [PWM_BITS-1:0] w_target;
            assign w_target = r_led_in_q[gi] ? r_max_level_q : '0;

            led_fade_channel #(
                .PWM_BITS (PWM_BITS)
            ) u_ch (
                .clck      (clck),
                .reset     (reset),
                .step_tick (w_step_tick),
                .enable    (enable),
                .pwm_cnt   (r_pwm_cnt),
                .target    (w_target),
                .led_bit   (w_led_bits[gi]),
                .moving    (w_moving[gi])
            );
        end
    endgenerate

    assign led_out = w_led_bits;
    assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_fader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pwm_fader
//  Description : Self-checking bench for led_pwm_fader (PWM_BITS=4,
//                STEP_DIV=4) against a behavioural brightness model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pwm_fader;

    localparam int CH   = 4;
    localparam int PB   = 4;
    localparam int SD   = 4;
    localparam int FULL = (1 << PB) - 1;

    logic          clck = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] led_in = '0;
    logic          enable = 1'b1;
    logic [PB-1:0] max_level = '0;
    logic [CH-1:0] led_out;
    logic          busy;

    int checks = 0;
    int errors = 0;

    led_pwm_fader #(
        .CHANNELS (CH),
        .PWM_BITS (PB),
        .STEP_DIV (SD)
    ) dut (
        .clck      (clck),
        .reset     (reset),
        .led_in    (led_in),
        .enable    (enable),
        .max_level (max_level),
        .led_out   (led_out),
        .busy      (busy)
    );

    always #5 clck = ~clck;

    // Behavioural model: brightness walks toward its target one unit per tick
    int      m_lvl [CH];
    bit      m_mv  [CH];
    int      m_pwm, m_div, m_max;
    bit      m_lin [CH];
    bit      m_busy;
    logic [CH-1:0] m_out;
    int      t_tgt, t_d;
    bit      t_any;

    always @(posedge clck) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                m_lvl[i] = 0; m_mv[i] = 0; m_lin[i] = 0;
            end
            m_pwm = 0; m_div = 0; m_max = 0; m_busy = 0; m_out = '0;
        end else begin
            t_any = 0;
            for (int i = 0; i < CH; i++) t_any = t_any | m_mv[i];
            m_busy = t_any;
            for (int i = 0; i < CH; i++) m_out[i] = enable && (m_pwm < m_lvl[i]);
            if (enable && m_div == SD - 1) begin
                for (int i = 0; i < CH; i++) begin
                    t_tgt    = m_lin[i] ? m_max : 0;
                    t_d      = t_tgt - m_lvl[i];
                    m_mv[i]  = (t_d != 0);
                    m_lvl[i] = m_lvl[i] + ((t_d > 0) ? 1 : (t_d < 0) ? -1 : 0);
                end
            end
            m_pwm = enable ? (m_pwm + 1) % FULL : 0;
            m_div = enable ? (m_div + 1) % SD : 0;
            for (int i = 0; i < CH; i++) m_lin[i] = led_in[i];
            m_max = int'(max_level);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of outputs against the model
    always @(negedge clck) begin
        chk("led_out_model", int'(led_out), int'(m_out));
        chk("busy_model", int'(busy), int'(m_busy));
    end

    task automatic wait_lvl(input int ch, input int v, input string nm);
        int k;
        k = 0;
        while (m_lvl[ch] != v && k < 400) begin
            @(negedge clck);
            k++;
        end
        if (m_lvl[ch] != v) chk(nm, m_lvl[ch], v);
    endtask

    task automatic wait_idle(input string nm);
        int k;
        repeat (8) @(negedge clck);
        k = 0;
        while (busy && k < 400) begin
            @(negedge clck);
            k++;
        end
        if (busy) chk(nm, int'(busy), 0);
    endtask

    initial begin
        int  k, highs;
        bit  gap;
        int  r;

        // Reset dominance
        led_in = 4'hF; max_level = 4'd15; enable = 1'b1; reset = 1'b1;
        repeat (20) begin
            @(negedge clck);
            chk("rst_led_out", int'(led_out), 0);
            chk("rst_busy", int'(busy), 0);
        end

        // Full rise on channel 0
        reset = 1'b0; led_in = 4'b0001; max_level = 4'd15;
        gap = 0;
        for (k = 1; k <= 200; k++) begin
            @(negedge clck);
            if (k == 1) chk("post_rst_out", int'(led_out), 0);
            if (k >= 5 && k <= 64 && !busy) gap = 1;
            if (k > 8 && !busy) break;
        end
        chk("rise_len", k, 65);
        chk("rise_busy_gap", int'(gap), 0);
        chk("rise_model_lvl", m_lvl[0], 15);
        repeat (30) begin
            @(negedge clck);
            chk("full_on_out", int'(led_out), 4'b0001);
        end

        // Duty cycle at max_level 5
        max_level = 4'd5;
        repeat (100) @(negedge clck);
        highs = 0;
        repeat (15) begin
            @(negedge clck);
            highs += int'(led_out[0]);
        end
        chk("duty_5", highs, 5);

        // Fall from 15 to 0
        max_level = 4'd15;
        wait_idle("rise15_timeout");
        led_in = 4'b0000;
        wait_idle("fall_timeout");
        chk("fall_model_lvl", m_lvl[0], 0);
        repeat (20) begin
            @(negedge clck);
            chk("fall_off_out", int'(led_out), 0);
        end

        // Reversal at level 7
        led_in = 4'b0001;
        wait_lvl(0, 7, "rev_wait7");
        led_in = 4'b0000;
        repeat (5) @(negedge clck);
        chk("rev_lvl6", m_lvl[0], 6);
        chk("rev_busy", int'(busy), 1);
        wait_idle("rev_idle");

        // Blank at level 9
        led_in = 4'b0001;
        wait_lvl(0, 9, "blank_wait9");
        enable = 1'b0;
        @(negedge clck);
        chk("blank_out_next", int'(led_out), 0);
        repeat (50) begin
            @(negedge clck);
            chk("blank_out_hold", int'(led_out), 0);
            chk("blank_busy_hold", int'(busy), 1);
        end
        chk("blank_lvl9", m_lvl[0], 9);
        enable = 1'b1;
        wait_idle("resume_idle");
        chk("resume_lvl15", m_lvl[0], 15);

        // Reset pulse mid-ramp at level 9
        led_in = 4'b0000;
        wait_lvl(0, 9, "rst_wait9");
        reset = 1'b1;
        @(negedge clck);
        chk("midrst_out", int'(led_out), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_lvl", m_lvl[0], 0);
        reset = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(negedge clck);
            r = int'($urandom_range(0, 199));
            reset = 1'b0;
            if (r < 10) led_in = 4'($urandom);
            else if (r < 14) max_level = 4'($urandom_range(0, 15));
            else if (r < 16) enable = 1'b0;
            else if (r < 30) enable = 1'b1;
            else if (r == 199) reset = 1'b1;
        end
        reset = 1'b0; enable = 1'b1;
        repeat (5) @(negedge clck);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
